latch_bank_arbiter: RTL and testbench
=====================================

LATCH_BANK_ARBITER -- requirements
Module: latch_bank_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of each latch word.
REQ-002 Parameter ADDR_W, default 3, latch bank address width; bank depth = 2**ADDR_W.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  asynchronous reset, active-high.
REQ-005 Req  input  4  per-requester write request; Req[i] for requester i.
REQ-006 ReqAddr  input  4*ADDR_W  target address; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-007 ReqData  input  4*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Gnt  output  4  one-hot grant; high for the owning requester for the whole transaction.
REQ-009 Done  output  4  one-hot, one-cycle completion pulse to the owning requester.
REQ-010 LatEn  output  2**ADDR_W  one-hot enable to latch bank word; never more than one bit high.
REQ-011 LatD  output  WIDTH  data driven to the latch bank D inputs.
REQ-012 Busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, SETUP, ENABLE, HOLD; all outputs registered or decoded from state and capture registers only, never directly from inputs.
REQ-014 IDLE: no Req bit high -> stay IDLE; otherwise select winner by round-robin, capture its address and data into internal registers, set Gnt[winner], go to SETUP.
REQ-015 Round-robin: search starts at pointer P (2 bits) and proceeds P, P+1, P+2, P+3 mod 4; first high Req bit wins.
REQ-016 SETUP (1 cycle): LatD = captured data, LatEn = 0, -> ENABLE.
REQ-017 ENABLE (1 cycle): LatEn[captured address] = 1, LatD = captured data, -> HOLD.
REQ-018 HOLD (1 cycle): LatEn = 0, LatD = captured data, Done[winner] = 1, P <= winner+1 mod 4, -> IDLE.
REQ-019 Gnt[winner] high in SETUP, ENABLE and HOLD; 0 in IDLE.
REQ-020 Latency: Req sampled high in IDLE at edge k -> Gnt high after edge k, LatEn high after edge k+1, Done high after edge k+2; one write per 4 cycles sustained.
REQ-021 LatD shall be stable from SETUP through HOLD (data setup and hold around the single LatEn pulse).
REQ-022 Req, ReqAddr, ReqData changes after capture are ignored; transaction always completes.
REQ-023 Requester holds Req until Done; Req still high in the IDLE cycle after Done re-enters arbitration with rotated priority.
REQ-024 Simultaneous requests: exactly one winner; losers receive no Gnt and keep waiting; no requester starves (served within 4 transactions).
REQ-025 LatD = 0 in IDLE.

Reset
REQ-026 Rst high forces immediately, without a clock edge: state IDLE, P = 0, Gnt = 0, Done = 0, LatEn = 0, LatD = 0, Busy = 0, capture registers = 0.
REQ-027 Rst asserted mid-transaction (including ENABLE) aborts it with no Done pulse; LatEn drops asynchronously.
REQ-028 First rising edge after Rst deasserts evaluates as IDLE with P = 0.

Verification
REQ-029 Single write: Req=0001, ReqAddr[0]=5, ReqData[0]=8'hA5 -> Gnt=0001 for 3 cycles, LatEn=8'h20 exactly one cycle (second), LatD=8'hA5 all 3 cycles, Done=0001 in third.
REQ-030 Contention from reset: Req=1111 held -> grant order 0,1,2,3,0; each Done one cycle; Gnt never multi-hot.
REQ-031 Rotation: after requester 2 served, Req=0101 -> requester 0 (P=3 wraps to 0) wins; next Req=0101 -> requester 2.
REQ-032 Input change: ReqData[1] changed 8'h11->8'hFF during SETUP -> LatD stays 8'h11 through HOLD.
REQ-033 Reset mid-ENABLE: Rst pulsed while LatEn=8'h01 -> LatEn, Gnt, Busy 0 immediately; no Done; next grant uses P=0.
REQ-034 Idle: Req=0000 for 10 cycles -> Busy=0, LatEn=0, LatD=0 throughout.

Source files
------------

// File: rtl/latch_bank_arbiter.sv
// Four-requester round-robin arbiter that writes one word into a latch bank
// with a SETUP / ENABLE / HOLD sequence around a single one-hot enable pulse.
module latch_bank_arbiter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [3:0]                Req,
    input  logic [4*ADDR_W-1:0]       ReqAddr,
    input  logic [4*WIDTH-1:0]        ReqData,
    output logic [3:0]                Gnt,
    output logic [3:0]                Done,
    output logic [(2**ADDR_W)-1:0]    LatEn,
    output logic [WIDTH-1:0]          LatD,
    output logic                      Busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned NREQ  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         win_q, win_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]   data_q, data_d;

    logic [3:0]         gnt_q, gnt_d;
    logic [3:0]         done_q, done_d;
    logic [DEPTH-1:0]   laten_q, laten_d;
    logic [WIDTH-1:0]   latd_q, latd_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [1:0]         pick;
    logic [1:0]         idx;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && Req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next state, capture registers and next registered outputs.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        addr_d  = addr_q;
        data_d  = data_q;
        gnt_d   = '0;
        done_d  = '0;
        laten_d = '0;
        latd_d  = '0;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    addr_d  = ReqAddr[int'(pick)*ADDR_W +: ADDR_W];
                    data_d  = ReqData[int'(pick)*WIDTH +: WIDTH];
                    gnt_d   = 4'(1) << pick;
                    latd_d  = ReqData[int'(pick)*WIDTH +: WIDTH];
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                gnt_d   = 4'(1) << win_q;
                laten_d = DEPTH'(1) << addr_q;
                latd_d  = data_q;
                busy_d  = 1'b1;
                state_d = ENABLE;
            end
            ENABLE: begin
                gnt_d   = 4'(1) << win_q;
                done_d  = 4'(1) << win_q;
                latd_d  = data_q;
                busy_d  = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                // Winner drops to lowest priority for the next arbitration.
                ptr_d   = win_q + 2'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            laten_q <= '0;
            latd_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            laten_q <= laten_d;
            latd_q  <= latd_d;
            busy_q  <= busy_d;
        end
    end

    assign Gnt   = gnt_q;
    assign Done  = done_q;
    assign LatEn = laten_q;
    assign LatD  = latd_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed bench for latch_bank_arbiter: single write, contention, rotation,
// input changes after capture, reset mid-ENABLE and idle behaviour.
module tb_latch_bank_arbiter;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned ADDR_W = 3;

    logic                  Clk;
    logic                  Rst;
    logic [3:0]            Req;
    logic [4*ADDR_W-1:0]   ReqAddr;
    logic [4*WIDTH-1:0]    ReqData;
    logic [3:0]            Gnt;
    logic [3:0]            Done;
    logic [7:0]            LatEn;
    logic [WIDTH-1:0]      LatD;
    logic                  Busy;

    int n_chk  = 0;
    int n_pass = 0;

    latch_bank_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Req     (Req),
        .ReqAddr (ReqAddr),
        .ReqData (ReqData),
        .Gnt     (Gnt),
        .Done    (Done),
        .LatEn   (LatEn),
        .LatD    (LatD),
        .Busy    (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        ReqAddr[i*ADDR_W +: ADDR_W] = a;
        ReqData[i*WIDTH +: WIDTH]   = d;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},   32'(Gnt),   32'h0);
        check({tag, "_done"},  32'(Done),  32'h0);
        check({tag, "_laten"}, 32'(LatEn), 32'h0);
        check({tag, "_latd"},  32'(LatD),  32'h0);
        check({tag, "_busy"},  32'(Busy),  32'h0);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        #1;
        check_quiet("rst");
        step();
        check_quiet("rst_clk");
        Rst = 1'b0;
    endtask

    // Four cycles of one transaction: SETUP, ENABLE, HOLD, then back in IDLE.
    task automatic run_txn(input string tag, input logic [3:0] g, input logic [7:0] en,
                           input logic [7:0] d, input bit corrupt, input int who);
        step();
        check({tag, "_setup_gnt"},   32'(Gnt),   32'(g));
        check({tag, "_setup_laten"}, 32'(LatEn), 32'h0);
        check({tag, "_setup_latd"},  32'(LatD),  32'(d));
        check({tag, "_setup_busy"},  32'(Busy),  32'h1);
        check({tag, "_setup_done"},  32'(Done),  32'h0);
        if (corrupt) begin
            ReqData[who*WIDTH +: WIDTH]   = 8'hFF;
            ReqAddr[who*ADDR_W +: ADDR_W] = 3'd0;
            Req = 4'b0000;
        end
        step();
        check({tag, "_en_gnt"},   32'(Gnt),   32'(g));
        check({tag, "_en_laten"}, 32'(LatEn), 32'(en));
        check({tag, "_en_latd"},  32'(LatD),  32'(d));
        check({tag, "_en_done"},  32'(Done),  32'h0);
        step();
        check({tag, "_hold_gnt"},   32'(Gnt),   32'(g));
        check({tag, "_hold_laten"}, 32'(LatEn), 32'h0);
        check({tag, "_hold_latd"},  32'(LatD),  32'(d));
        check({tag, "_hold_done"},  32'(Done),  32'(g));
        step();
        check_quiet({tag, "_idle"});
    endtask

    logic [3:0] g_tab  [5];
    logic [7:0] en_tab [5];
    logic [7:0] d_tab  [5];

    initial begin
        Rst     = 1'b1;
        Req     = 4'b0000;
        ReqAddr = '0;
        ReqData = '0;

        // Reset state
        step();
        check_quiet("init");
        Rst = 1'b0;

        // Single write: requester 0, address 5, data A5
        set_req(0, 3'd5, 8'hA5);
        Req = 4'b0001;
        run_txn("single", 4'b0001, 8'h20, 8'hA5, 1'b0, 0);
        Req = 4'b0000;

        // Contention from reset: all four held, order 0,1,2,3,0
        do_reset();
        set_req(0, 3'd1, 8'h5A);
        set_req(1, 3'd2, 8'h3C);
        set_req(2, 3'd4, 8'hC3);
        set_req(3, 3'd7, 8'h96);
        g_tab  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        en_tab = '{8'h02,   8'h04,   8'h10,   8'h80,   8'h02};
        d_tab  = '{8'h5A,   8'h3C,   8'hC3,   8'h96,   8'h5A};
        Req = 4'b1111;
        for (int t = 0; t < 5; t++)
            run_txn($sformatf("cont%0d", t), g_tab[t], en_tab[t], d_tab[t], 1'b0, 0);

        // Rotation: requester 2 served, then 0101 picks 0, then 2
        Req = 4'b0100;
        run_txn("rot_r2", 4'b0100, 8'h10, 8'hC3, 1'b0, 2);
        Req = 4'b0101;
        run_txn("rot_wrap", 4'b0001, 8'h02, 8'h5A, 1'b0, 0);
        run_txn("rot_next", 4'b0100, 8'h10, 8'hC3, 1'b0, 2);

        // Input change after capture is ignored
        set_req(1, 3'd3, 8'h11);
        Req = 4'b0010;
        run_txn("inchg", 4'b0010, 8'h08, 8'h11, 1'b1, 1);

        // Reset mid-ENABLE
        set_req(0, 3'd0, 8'h3C);
        Req = 4'b0001;
        step();
        check("rme_setup_gnt", 32'(Gnt), 32'h1);
        step();
        check("rme_en_laten", 32'(LatEn), 32'h01);
        #2;
        Rst = 1'b1;
        #1;
        check_quiet("rme_async");
        #2;
        Rst = 1'b0;
        // P restarts at 0: requester 1 must beat requester 2
        set_req(1, 3'd6, 8'h77);
        set_req(2, 3'd3, 8'h88);
        Req = 4'b0110;
        run_txn("rme_next", 4'b0010, 8'h40, 8'h77, 1'b0, 1);

        // Idle for 10 cycles
        Req = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("idle%0d_busy", c),  32'(Busy),  32'h0);
            check($sformatf("idle%0d_laten", c), 32'(LatEn), 32'h0);
            check($sformatf("idle%0d_latd", c),  32'(LatD),  32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
